platform_rst_seq: RTL and testbench

- Parametrised platform clock-lock and reset sequencer; the successor to gating the platform reset directly with the PLL LOCK.
- Filters the asynchronous PLL lock and holds all domains in reset for a fixed time.
- Releases NUM_DOM reset domains one at a time, in index order, with per-domain ready handshakes (e.g. SDRAM controller before CPU).
- Re-sequences on PLL lock loss or on a software reset request. Sits between the PLL and the platform top.

---
 rtl/platform_rst_seq.sv | 193 +++++++++++++++++++
 tb/tb_platform_rst_seq.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/platform_rst_seq.sv
// platform_rst_seq: PLL-lock filter and multi-domain reset sequencer.
// Filters the asynchronous PLL lock, holds all domains in reset for a fixed
// time, then releases domains one at a time in index order. Each release
// waits for the previous domain's ready ack. The sequencer restarts on lock
// loss or on a software request made while in RUN.
// Optional build macro PLATFORM_RST_ACK_TIMEOUT_EN adds a per-domain ack
// timeout with sticky ack_to_o flags. Without it, ack_to_o is tied to 0.
module platform_rst_seq #(
  parameter int unsigned NUM_DOM     = 3,
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned STEP_CYCLES = 8,
  parameter int unsigned LOCK_FILT   = 4,
  parameter int unsigned ACK_TO      = 1024,
  parameter int unsigned CNT_W       = 16
) (
  input  logic               clk_i,
  input  logic               reset_n,
  input  logic               pll_lock_i,
  input  logic               sw_rst_req_i,
  input  logic [NUM_DOM-1:0] dom_ack_i,
  input  logic               lock_lost_clr_i,
  output logic [NUM_DOM-1:0] rst_n_o,
  output logic               busy_o,
  output logic               lock_lost_o,
  output logic [1:0]         state_o,
  output logic [NUM_DOM-1:0] ack_to_o
);

  localparam int unsigned IDX_W  = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;
  localparam int unsigned FILT_W = $clog2(LOCK_FILT + 1);

  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(LOCK_FILT - 1);
  localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  STEP_LAST = CNT_W'(STEP_CYCLES - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DOM - 1);

  localparam logic [1:0] ST_WAIT_LOCK = 2'd0;
  localparam logic [1:0] ST_HOLD      = 2'd1;
  localparam logic [1:0] ST_REL       = 2'd2;
  localparam logic [1:0] ST_RUN       = 2'd3;

  // The shared counter has to cover the longest interval it ever times.
  localparam longint unsigned NEED_HS  = (HOLD_CYCLES > STEP_CYCLES) ? HOLD_CYCLES : STEP_CYCLES;
  localparam longint unsigned CNT_NEED = (NEED_HS > ACK_TO) ? NEED_HS : ACK_TO;

  if (NUM_DOM < 1 || NUM_DOM > 8 || HOLD_CYCLES < 1 || STEP_CYCLES < 1 ||
      LOCK_FILT < 1 || (CNT_NEED >> CNT_W) != 0) begin : g_bad_cfg
    $error("platform_rst_seq: illegal parameter set");
  end

  logic               lock_meta_q, lock_sync_q;
  logic [FILT_W-1:0]  filt_q, filt_d;
  logic               lock_ok;
  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [NUM_DOM-1:0] rst_q, rst_d;
  logic               busy_q, busy_d;
  logic               lock_lost_q, lock_lost_d;
  logic               ack_now, adv;

`ifdef PLATFORM_RST_ACK_TIMEOUT_EN
  // A timeout shorter than the release step would never be seen, so clamp it up.
  localparam int unsigned      TO_EFF  = (ACK_TO > STEP_CYCLES) ? ACK_TO : STEP_CYCLES;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_EFF - 1);
  logic [NUM_DOM-1:0] ack_to_q, ack_to_d;
`endif

  // Two-flop synchroniser for the asynchronous PLL lock.
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      lock_meta_q <= 1'b0;
      lock_sync_q <= 1'b0;
    end else begin
      lock_meta_q <= pll_lock_i;
      lock_sync_q <= lock_meta_q;
    end
  end

  // Lock filter: count consecutive synced-high samples; a low sample drops lock_ok at once.
  always_comb begin
    filt_d = filt_q;
    if (!lock_sync_q)           filt_d = '0;
    else if (filt_q < FILT_LAST) filt_d = filt_q + 1'b1;
    lock_ok = lock_sync_q && (filt_q >= FILT_LAST);
  end

  // Sequencer next state: lock loss beats sw request, which beats advance.
  always_comb begin
    state_d     = state_q;
    cnt_d       = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    idx_d       = idx_q;
    rst_d       = rst_q;
    lock_lost_d = lock_lost_q & ~lock_lost_clr_i;
    ack_now     = dom_ack_i[idx_q];
    adv         = 1'b0;
`ifdef PLATFORM_RST_ACK_TIMEOUT_EN
    ack_to_d    = ack_to_q;
`endif
    if (state_q != ST_WAIT_LOCK && !lock_ok) begin
      state_d     = ST_WAIT_LOCK;
      rst_d       = '0;
      cnt_d       = '0;
      idx_d       = '0;
      lock_lost_d = 1'b1;
    end else begin
      case (state_q)
        ST_WAIT_LOCK: begin
          rst_d = '0;
          cnt_d = '0;
          idx_d = '0;
          if (lock_ok) state_d = ST_HOLD;
        end
        ST_HOLD: begin
          rst_d = '0;
          if (cnt_q >= HOLD_LAST) begin
            state_d  = ST_REL;
            cnt_d    = '0;
            idx_d    = '0;
            rst_d[0] = 1'b1;
          end
        end
        ST_REL: begin
          adv = ack_now && (cnt_q >= STEP_LAST);
`ifdef PLATFORM_RST_ACK_TIMEOUT_EN
          if (!ack_now && (cnt_q >= TO_LAST)) begin
            adv             = 1'b1;
            ack_to_d[idx_q] = 1'b1;
          end
`endif
          if (adv) begin
            cnt_d = '0;
            if (idx_q == IDX_LAST) begin
              state_d = ST_RUN;
            end else begin
              idx_d = idx_q + 1'b1;
              for (int i = 0; i < NUM_DOM; i++)
                if (idx_d == IDX_W'(i)) rst_d[i] = 1'b1;
            end
          end
        end
        default: begin
          rst_d = '1;
          cnt_d = '0;
          if (sw_rst_req_i) begin
            state_d = ST_HOLD;
            rst_d   = '0;
            idx_d   = '0;
          end
        end
      endcase
    end
    busy_d = (state_d != ST_RUN);
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      filt_q      <= '0;
      state_q     <= ST_WAIT_LOCK;
      cnt_q       <= '0;
      idx_q       <= '0;
      rst_q       <= '0;
      busy_q      <= 1'b1;
      lock_lost_q <= 1'b0;
    end else begin
      filt_q      <= filt_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      rst_q       <= rst_d;
      busy_q      <= busy_d;
      lock_lost_q <= lock_lost_d;
    end
  end

`ifdef PLATFORM_RST_ACK_TIMEOUT_EN
  // Sticky per-domain timeout flags; only reset_n clears them.
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) ack_to_q <= '0;
    else          ack_to_q <= ack_to_d;
  end
  assign ack_to_o = ack_to_q;
`else
  assign ack_to_o = '0;
`endif

  assign rst_n_o     = rst_q;
  assign busy_o      = busy_q;
  assign lock_lost_o = lock_lost_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_platform_rst_seq.sv
// Bench for platform_rst_seq. Expected release edges are computed from the
// hold, step and ack-delay rules. Outputs are sampled on the falling edge.
module tb_platform_rst_seq;
  localparam int N      = 3;
  localparam int HOLD   = 16;
  localparam int STEP   = 8;
  localparam int LF     = 4;
  localparam int ACKTO  = 32;
  localparam int TO_EFF = (ACKTO > STEP) ? ACKTO : STEP;

  logic         clk_i = 1'b0, reset_n = 1'b0, pll_lock_i = 1'b0;
  logic         sw_rst_req_i = 1'b0, lock_lost_clr_i = 1'b0;
  logic [N-1:0] dom_ack_i = '0;
  logic [N-1:0] rst_n_o, ack_to_o;
  logic         busy_o, lock_lost_o;
  logic [1:0]   state_o;

  int checks = 0, failures = 0;
  int cyc = 0;
  int rel_cyc;
  int dly[N];
  bit keep[N];
  logic [N-1:0] to_base = '0;

  platform_rst_seq #(.NUM_DOM(N), .HOLD_CYCLES(HOLD), .STEP_CYCLES(STEP),
                     .LOCK_FILT(LF), .ACK_TO(ACKTO), .CNT_W(16)) dut (
    .clk_i(clk_i), .reset_n(reset_n), .pll_lock_i(pll_lock_i),
    .sw_rst_req_i(sw_rst_req_i), .dom_ack_i(dom_ack_i),
    .lock_lost_clr_i(lock_lost_clr_i), .rst_n_o(rst_n_o), .busy_o(busy_o),
    .lock_lost_o(lock_lost_o), .state_o(state_o), .ack_to_o(ack_to_o));

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1);
  end

  // Runs one full sequence whose HOLD entry is edge h and checks every cycle.
  // Release edge of domain i+1 = release of i + max(STEP, ack delay + 1),
  // capped at the timeout when that feature is built in.
  task automatic run_sequence(input int h, input string nm, input int sw_at, input logic exp_ll);
    int r[N+1];
    int to_e[N];
    int adv;
    logic [N-1:0] exp_rst, exp_to, a;
    logic [1:0] exp_st;
    r[0] = h + HOLD;
    for (int i = 0; i < N; i++) begin
      adv = (dly[i] + 1 > STEP) ? dly[i] + 1 : STEP;
      to_e[i] = -1;
`ifdef PLATFORM_RST_ACK_TIMEOUT_EN
      if (dly[i] + 1 > TO_EFF) begin
        adv = TO_EFF;
        to_e[i] = r[i] + adv;
      end
`endif
      r[i+1] = r[i] + adv;
    end
    while (cyc < r[N] + 3) begin
      @(negedge clk_i);
      if (cyc >= h) begin
        for (int i = 0; i < N; i++) exp_rst[i] = (cyc >= r[i]);
        exp_st = (cyc < r[0]) ? 2'd1 : (cyc < r[N]) ? 2'd2 : 2'd3;
        exp_to = to_base;
        for (int i = 0; i < N; i++) if (to_e[i] >= 0 && cyc >= to_e[i]) exp_to[i] = 1'b1;
        checks++;
        if (rst_n_o !== exp_rst) begin
          failures++;
          $display("FAIL %s rst_n_o cyc=%0d got=%b exp=%b", nm, cyc, rst_n_o, exp_rst);
        end
        checks++;
        if (state_o !== exp_st) begin
          failures++;
          $display("FAIL %s state_o cyc=%0d got=%0d exp=%0d", nm, cyc, state_o, exp_st);
        end
        checks++;
        if (busy_o !== (cyc < r[N])) begin
          failures++;
          $display("FAIL %s busy_o cyc=%0d got=%b exp=%b", nm, cyc, busy_o, (cyc < r[N]));
        end
        checks++;
        if (lock_lost_o !== exp_ll) begin
          failures++;
          $display("FAIL %s lock_lost_o cyc=%0d got=%b exp=%b", nm, cyc, lock_lost_o, exp_ll);
        end
        checks++;
        if (ack_to_o !== exp_to) begin
          failures++;
          $display("FAIL %s ack_to_o cyc=%0d got=%b exp=%b", nm, cyc, ack_to_o, exp_to);
        end
      end
      for (int i = 0; i < N; i++) a[i] = (cyc >= r[i] + dly[i]) && (keep[i] || cyc < r[i+1]);
      dom_ack_i    = a;
      sw_rst_req_i = (cyc == sw_at - 1);
    end
    for (int i = 0; i < N; i++) if (to_e[i] >= 0) to_base[i] = 1'b1;
    sw_rst_req_i = 1'b0;
  endtask

  task automatic tie_acks();
    for (int i = 0; i < N; i++) begin dly[i] = -1000; keep[i] = 1'b1; end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk_i);
    checks++; if (rst_n_o !== '0)    begin failures++; $display("FAIL reset rst_n_o got=%b exp=000", rst_n_o); end
    checks++; if (busy_o !== 1'b1)   begin failures++; $display("FAIL reset busy_o got=%b exp=1", busy_o); end
    checks++; if (lock_lost_o !== 0) begin failures++; $display("FAIL reset lock_lost_o got=%b exp=0", lock_lost_o); end
    checks++; if (state_o !== 2'd0)  begin failures++; $display("FAIL reset state_o got=%0d exp=0", state_o); end
    checks++; if (ack_to_o !== '0)   begin failures++; $display("FAIL reset ack_to_o got=%b exp=000", ack_to_o); end
    reset_n = 1'b1;
    rel_cyc = cyc;
  endtask

  // Lock is first sampled at edge rel+10; two sync flops plus LF filter samples follow.
  task automatic test_nominal();
    tie_acks();
    while (cyc < rel_cyc + 9) @(negedge clk_i);
    pll_lock_i = 1'b1;
    run_sequence(rel_cyc + 10 + 1 + LF, "nominal", -1, 1'b0);
  endtask

  task automatic test_sw_rst();
    int h;
    tie_acks();
    @(negedge clk_i);
    sw_rst_req_i = 1'b1;
    h = cyc + 1;
    run_sequence(h, "sw_rst", h + HOLD + 3, 1'b0);
  endtask

  task automatic test_ack_stall();
    int h;
    tie_acks();
    dly[1] = 100;
    keep[1] = 1'b0;
    @(negedge clk_i);
    sw_rst_req_i = 1'b1;
    h = cyc + 1;
    run_sequence(h, "ack_stall", -1, 1'b0);
  endtask

  task automatic test_lock_loss();
    int e;
    tie_acks();
    @(negedge clk_i);
    e = cyc;
    checks++; if (state_o !== 2'd3) begin failures++; $display("FAIL lock_loss pre state_o got=%0d exp=3", state_o); end
    pll_lock_i = 1'b0;
    lock_lost_clr_i = 1'b1;
    @(negedge clk_i);
    pll_lock_i = 1'b1;
    while (cyc < e + 3) @(negedge clk_i);
    lock_lost_clr_i = 1'b0;
    checks++; if (rst_n_o !== '0)   begin failures++; $display("FAIL lock_loss rst_n_o got=%b exp=000", rst_n_o); end
    checks++; if (state_o !== 2'd0) begin failures++; $display("FAIL lock_loss state_o got=%0d exp=0", state_o); end
    checks++; if (lock_lost_o !== 1'b1) begin failures++; $display("FAIL lock_loss set_wins lock_lost_o got=%b exp=1", lock_lost_o); end
    checks++; if (busy_o !== 1'b1)  begin failures++; $display("FAIL lock_loss busy_o got=%b exp=1", busy_o); end
    run_sequence(e + 3 + LF, "relock", -1, 1'b1);
    lock_lost_clr_i = 1'b1;
    @(negedge clk_i);
    lock_lost_clr_i = 1'b0;
    checks++; if (lock_lost_o !== 1'b0) begin failures++; $display("FAIL lost_clr lock_lost_o got=%b exp=0", lock_lost_o); end
    checks++; if (rst_n_o !== '1)   begin failures++; $display("FAIL lost_clr rst_n_o got=%b exp=111", rst_n_o); end
  endtask

  task automatic test_random();
    int h, sw_at;
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < N; i++) begin
        dly[i]  = int'($urandom_range(45, 0)) - 5;
        keep[i] = 1'($urandom_range(1, 0));
      end
      @(negedge clk_i);
      sw_rst_req_i = 1'b1;
      h = cyc + 1;
      sw_at = ($urandom_range(1, 0) == 1) ? h + HOLD + int'($urandom_range(5, 0)) : -1;
      run_sequence(h, "random", sw_at, 1'b0);
    end
  endtask

`ifdef PLATFORM_RST_ACK_TIMEOUT_EN
  task automatic test_ack_timeout();
    int h;
    tie_acks();
    dly[0] = 1000;
    keep[0] = 1'b0;
    @(negedge clk_i);
    sw_rst_req_i = 1'b1;
    h = cyc + 1;
    run_sequence(h, "ack_timeout", -1, 1'b0);
  endtask
`endif

  // Three synced-high samples are one short of the filter length.
  task automatic test_glitch();
    pll_lock_i = 1'b0;
    dom_ack_i  = '0;
    @(negedge clk_i);
    reset_n = 1'b0;
    to_base = '0;
    repeat (2) @(negedge clk_i);
    reset_n = 1'b1;
    repeat (5) @(negedge clk_i);
    pll_lock_i = 1'b1;
    repeat (3) @(negedge clk_i);
    pll_lock_i = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_i);
      checks++;
      if (state_o !== 2'd0 || rst_n_o !== '0 || busy_o !== 1'b1) begin
        failures++;
        $display("FAIL glitch cyc=%0d state_o=%0d rst_n_o=%b busy_o=%b exp 0/000/1", cyc, state_o, rst_n_o, busy_o);
      end
    end
  endtask

  task automatic test_async_reset();
    int h;
    dom_ack_i = '0;
    @(negedge clk_i);
    pll_lock_i = 1'b1;
    h = cyc + 1 + 1 + LF;
    while (cyc < h + HOLD + 3) @(negedge clk_i);
    checks++;
    if (rst_n_o !== 3'b001 || state_o !== 2'd2) begin
      failures++;
      $display("FAIL async_pre rst_n_o=%b state_o=%0d exp 001/2", rst_n_o, state_o);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (rst_n_o !== '0 || busy_o !== 1'b1 || lock_lost_o !== 1'b0 || state_o !== 2'd0 || ack_to_o !== '0) begin
      failures++;
      $display("FAIL async_reset rst_n_o=%b busy=%b ll=%b state=%0d ack_to=%b", rst_n_o, busy_o, lock_lost_o, state_o, ack_to_o);
    end
    @(posedge clk_i);
    #1;
    checks++;
    if (rst_n_o !== '0 || state_o !== 2'd0) begin
      failures++;
      $display("FAIL async_hold rst_n_o=%b state_o=%0d exp 000/0", rst_n_o, state_o);
    end
    reset_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_sw_rst();
    test_ack_stall();
    test_lock_loss();
    test_random();
`ifdef PLATFORM_RST_ACK_TIMEOUT_EN
    test_ack_timeout();
`endif
    test_glitch();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
